// File: rtl/rbt_phv_defs.sv
// Shared PHV layout, tag indices and Ethernet constants for the send pipeline.
// Layout is LSB first: B[7]x8 | H[2]x16 | W[10]x32.
package rbt_phv_defs;

  localparam int PHV_B_NUM = 7;
  localparam int PHV_H_NUM = 2;
  localparam int PHV_W_NUM = 10;

  localparam int PHV_B_BASE    = 0;
  localparam int PHV_H_BASE    = PHV_B_BASE + PHV_B_NUM * 8;
  localparam int PHV_W_BASE    = PHV_H_BASE + PHV_H_NUM * 16;
  localparam int PHV_WIDTH_DEF = PHV_W_BASE + PHV_W_NUM * 32;

  // Bit positions of the protocol tags inside W[0].
  localparam int TAG_ETH  = 0;
  localparam int TAG_VLAN = 1;
  localparam int TAG_IPV4 = 2;
  localparam int TAG_IPV6 = 4;

  localparam int IP_OFFSET_NO    = 4;
  localparam int SEATL_OFFSET_NO = 6;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETYPE_VLAN = 16'h8100;

  localparam logic [7:0] ETH_HLEN  = 8'd14;
  localparam logic [7:0] VLAN_HLEN = 8'd18;

  function automatic int b_lsb(input int idx);
    return PHV_B_BASE + 8 * idx;
  endfunction

  function automatic int h_lsb(input int idx);
    return PHV_H_BASE + 16 * idx;
  endfunction

  function automatic int w_lsb(input int idx);
    return PHV_W_BASE + 32 * idx;
  endfunction

endpackage

// File: rtl/rbt_s_eth_deparser_if.sv
// Proto-header beat bus: valid/ready handshake carrying length, header data and PHV.
interface rbt_s_eth_deparser_if
  import rbt_phv_defs::*;
#(
  parameter int HEADER_WIDTH = 2048,
  parameter int PHV_WIDTH    = PHV_WIDTH_DEF
) ();

  logic                    valid;
  logic                    ready;
  logic [15:0]             length;
  logic [HEADER_WIDTH-1:0] data;
  logic [PHV_WIDTH-1:0]    phv;

  modport master (output valid, length, data, phv, input ready);
  modport slave  (input valid, length, data, phv, output ready);

endinterface

// File: rtl/rbt_hdr_skid_reg.sv
// Generic valid/ready register stage with a one-entry skid; s_ready_o is registered
// and is simply the inverse of the skid occupancy.
module rbt_hdr_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         ready_q;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         s_fire;
  logic         main_free;

  // NOTE: every next-state signal gets a default first, so no latches are inferred.
  always_comb begin
    main_v_d  = main_v_q;
    main_d    = main_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    s_fire    = s_valid_i & ready_q;
    main_free = ~main_v_q | m_ready_i;

    if (main_free) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = s_fire;
        if (s_fire) main_d = s_data_i;
      end
    end else if (s_fire) begin
      // Ready was still high for this beat; park it until the main slot frees.
      skid_v_d = 1'b1;
      skid_d   = s_data_i;
    end
  end

  // NOTE: payload registers are reset as well so the outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ~skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = main_v_q;
  assign m_data_o  = main_q;

endmodule

// File: rtl/rbt_s_eth_deparser.sv
// Prepends a 14-byte (or 18-byte with 802.1Q) Ethernet header to an L3-aligned proto-header
// beat and rewinds the PHV offsets. Stage 1 is the skid register, stage 2 the framed output.
module rbt_s_eth_deparser
  import rbt_phv_defs::*;
#(
  parameter int HEADER_WIDTH = 2048,
  parameter int PHV_WIDTH    = PHV_WIDTH_DEF,
  parameter int DMAC_W_NO    = 1,
  parameter int SMAC_W_NO    = 2,
  parameter int VLAN_W_NO    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  rbt_s_eth_deparser_if.slave         in_if,
  rbt_s_eth_deparser_if.master        out_if,
  output logic [31:0]                 drop_cnt
);

  localparam int          HW        = HEADER_WIDTH;
  localparam logic [16:0] MAX_BYTES = 17'(HW / 8);

  typedef struct packed {
    logic [HW-1:0]        data;
    logic [PHV_WIDTH-1:0] phv;
    logic [15:0]          length;
    logic [15:0]          etype;
    logic                 vlan;
    logic                 drop;
  } s1_t;

  s1_t        s1_in;
  s1_t        s1;
  logic       s1_valid;
  logic       s1_ready;
  logic       s1_fire;
  logic       s2_free;
  logic [7:0] in_hlen;

  // Tag decode and overflow test happen before stage 1 so stage 2 only builds the header.
  always_comb begin
    s1_in.data   = in_if.data;
    s1_in.phv    = in_if.phv;
    s1_in.length = in_if.length;
    s1_in.vlan   = in_if.phv[w_lsb(0) + TAG_VLAN];
    in_hlen      = s1_in.vlan ? VLAN_HLEN : ETH_HLEN;
    // IPv6 wins over IPv4; untagged traffic also defaults to the IPv4 EtherType.
    if (in_if.phv[w_lsb(0) + TAG_IPV6])      s1_in.etype = ETYPE_IPV6;
    else if (in_if.phv[w_lsb(0) + TAG_IPV4]) s1_in.etype = ETYPE_IPV4;
    else                                     s1_in.etype = ETYPE_IPV4;
    s1_in.drop = ({1'b0, in_if.length} + 17'(in_hlen)) > MAX_BYTES;
  end

  rbt_hdr_skid_reg #(
    .W($bits(s1_t))
  ) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (in_if.valid),
    .s_ready_o (in_if.ready),
    .s_data_i  (s1_in),
    .m_valid_o (s1_valid),
    .m_ready_i (s1_ready),
    .m_data_o  (s1)
  );

  logic [47:0]          dmac;
  logic [47:0]          smac;
  logic [15:0]          tci;
  logic [7:0]           hlen;
  logic [HW-1:0]        hdr_d;
  logic [15:0]          len_d;
  logic [PHV_WIDTH-1:0] phv_d;
  logic                 unused_tail;

  assign unused_tail = ^s1.data[111:0];

  always_comb begin
    dmac = {s1.phv[h_lsb(0) +: 16], s1.phv[w_lsb(DMAC_W_NO) +: 32]};
    smac = {s1.phv[h_lsb(1) +: 16], s1.phv[w_lsb(SMAC_W_NO) +: 32]};
    tci  = s1.phv[w_lsb(VLAN_W_NO) +: 16];
    hlen = s1.vlan ? VLAN_HLEN : ETH_HLEN;
    if (s1.vlan) hdr_d = {dmac, smac, ETYPE_VLAN, tci, s1.etype, s1.data[HW-1:144]};
    else         hdr_d = {dmac, smac, s1.etype, s1.data[HW-1:112]};
    len_d = s1.length + 16'(hlen);
    phv_d = s1.phv;
    phv_d[w_lsb(0) + TAG_ETH]           = 1'b1;
    phv_d[b_lsb(IP_OFFSET_NO) +: 8]     = hlen;
    phv_d[b_lsb(SEATL_OFFSET_NO) +: 8]  = s1.phv[b_lsb(SEATL_OFFSET_NO) +: 8] + hlen;
  end

  logic                 out_v_q;
  logic [HW-1:0]        out_data_q;
  logic [15:0]          out_len_q;
  logic [PHV_WIDTH-1:0] out_phv_q;
  logic [31:0]          drop_cnt_q;

  // A beat being dropped never needs stage 2, so it leaves stage 1 regardless of backpressure.
  assign s2_free  = ~out_v_q | out_if.ready;
  assign s1_ready = s1.drop | s2_free;
  assign s1_fire  = s1_valid & s1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_len_q  <= '0;
      out_phv_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (s2_free) begin
        out_v_q <= s1_fire & ~s1.drop;
        if (s1_fire && !s1.drop) begin
          out_data_q <= hdr_d;
          out_len_q  <= len_d;
          out_phv_q  <= phv_d;
        end
      end
      if (s1_fire && s1.drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign out_if.valid  = out_v_q;
  assign out_if.data   = out_data_q;
  assign out_if.length = out_len_q;
  assign out_if.phv    = out_phv_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rbt_s_eth_deparser.sv
// Directed bench for rbt_s_eth_deparser: vector table for framing/PHV/overflow, plus
// hand-written sequences for streaming backpressure and reset with beats in flight.
module tb_rbt_s_eth_deparser;
  import rbt_phv_defs::*;

  localparam int HW = 2048;
  localparam int PW = 408;

  localparam logic [47:0] D0 = 48'h0A0000000001;
  localparam logic [47:0] S0 = 48'h0B0000000002;
  localparam logic [47:0] D1 = 48'h112233445566;
  localparam logic [47:0] S1 = 48'h778899AABBCC;
  localparam logic [HW-1:0] IN_DATA = {32'hC0FFEE11, 32'h22334455, {((HW - 64) / 8){8'hA5}}};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] drop_cnt;

  always #5 clk = ~clk;

  rbt_s_eth_deparser_if #(.HEADER_WIDTH(HW), .PHV_WIDTH(PW)) in_if ();
  rbt_s_eth_deparser_if #(.HEADER_WIDTH(HW), .PHV_WIDTH(PW)) out_if ();

  rbt_s_eth_deparser #(
    .HEADER_WIDTH(HW),
    .PHV_WIDTH   (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (in_if),
    .out_if  (out_if),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [7:0]   tags;
    logic [15:0]  len;
    logic [47:0]  dmac;
    logic [47:0]  smac;
    logic [15:0]  tci;
    logic [7:0]   b6;
    logic         drop;
    logic [15:0]  exp_len;
    logic [175:0] exp_top;
    logic [7:0]   exp_b4;
    logic [7:0]   exp_b6;
    logic [7:0]   exp_w0;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Layout written out by hand: B[i] at 8i, H[j] at 56+16j, W[k] at 88+32k.
  function automatic logic [PW-1:0] make_phv(input logic [7:0] tags, input logic [47:0] dmac,
                                             input logic [47:0] smac, input logic [15:0] tci,
                                             input logic [7:0] b6);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < 7; i++) p[8*i +: 8] = 8'(8'h30 + i);
    p[48 +: 8]  = b6;
    p[56 +: 16] = dmac[47:32];
    p[72 +: 16] = smac[47:32];
    for (int k = 0; k < 10; k++) p[88 + 32*k +: 32] = 32'h1000_0000 + 32'(k);
    p[88 +: 32]  = {24'h5A5A5A, tags};
    p[120 +: 32] = dmac[31:0];
    p[152 +: 32] = smac[31:0];
    p[184 +: 32] = {16'h1234, tci};
    return p;
  endfunction

  task automatic send(input logic [15:0] len, input logic [PW-1:0] phv);
    int t;
    t = 0;
    while (in_if.ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("send_ready_timeout", in_if.ready, 1'b1);
    in_if.valid  = 1'b1;
    in_if.length = len;
    in_if.data   = IN_DATA;
    in_if.phv    = phv;
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic run_stream(input bit toggle);
    int          sent, got, ord_err, stall_err, low_cycles, extra;
    bit          acc, prev_stall;
    logic [15:0] prev_len;
    sent = 0; got = 0; ord_err = 0; stall_err = 0; low_cycles = 0; extra = 0;
    acc = 1'b0; prev_stall = 1'b0; prev_len = '0;
    in_if.data = IN_DATA;
    in_if.phv  = make_phv(8'h00, D0, S0, 16'h0000, 8'h00);
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      if (acc) sent++;
      in_if.valid  = (sent < 8);
      in_if.length = 16'(sent * 4);
      if (in_if.ready !== 1'b1) low_cycles++;
      acc = in_if.valid && in_if.ready;
      out_if.ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (prev_stall && (!out_if.valid || out_if.length != prev_len)) stall_err++;
      if (out_if.valid && out_if.ready) begin
        if (out_if.length != 16'(got * 4 + 14)) ord_err++;
        got++;
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_len   = out_if.length;
      tick();
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    repeat (4) begin
      if (out_if.valid) extra++;
      tick();
    end
    check(toggle ? "toggle_got" : "stream_got", got, 8);
    check(toggle ? "toggle_sent" : "stream_sent", sent + int'(acc), 8);
    check(toggle ? "toggle_order" : "stream_order", ord_err, 0);
    check(toggle ? "toggle_hold" : "stream_hold", stall_err, 0);
    check(toggle ? "toggle_no_extra" : "stream_no_extra", extra, 0);
    if (toggle) check("toggle_backpressure", low_cycles > 0, 1'b1);
    else        check("stream_ready_high", low_cycles, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[10];
    int            exp_drops;
    int            seen;
    logic [PW-1:0] exp_phv;
    int            bad;

    vecs[0] = '{8'h10, 16'd40, D0, S0, 16'h0000, 8'h00, 1'b0, 16'd54,
                {D0, S0, 16'h86DD, 32'hC0FFEE11, 32'h22334455}, 8'h0E, 8'h0E, 8'h11};
    vecs[1] = '{8'h06, 16'd20, D0, S0, 16'h0064, 8'h00, 1'b0, 16'd38,
                {D0, S0, 16'h8100, 16'h0064, 16'h0800, 32'hC0FFEE11}, 8'h12, 8'h12, 8'h07};
    vecs[2] = '{8'h04, 16'd100, D1, S1, 16'h0000, 8'h20, 1'b0, 16'd114,
                {D1, S1, 16'h0800, 32'hC0FFEE11, 32'h22334455}, 8'h0E, 8'h2E, 8'h05};
    vecs[3] = '{8'h00, 16'd0, D0, S0, 16'h0000, 8'h05, 1'b0, 16'd14,
                {D0, S0, 16'h0800, 32'hC0FFEE11, 32'h22334455}, 8'h0E, 8'h13, 8'h01};
    vecs[4] = '{8'h16, 16'd60, D1, S1, 16'hABCD, 8'hF8, 1'b0, 16'd78,
                {D1, S1, 16'h8100, 16'hABCD, 16'h86DD, 32'hC0FFEE11}, 8'h12, 8'h0A, 8'h17};
    vecs[5] = '{8'h04, 16'd246, D0, S0, 16'h0000, 8'h00, 1'b1, 16'd0, 176'd0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{8'h10, 16'd242, D0, S0, 16'h0000, 8'h10, 1'b0, 16'd256,
                {D0, S0, 16'h86DD, 32'hC0FFEE11, 32'h22334455}, 8'h0E, 8'h1E, 8'h11};
    vecs[7] = '{8'h02, 16'd238, D0, S0, 16'h0FFF, 8'h00, 1'b0, 16'd256,
                {D0, S0, 16'h8100, 16'h0FFF, 16'h0800, 32'hC0FFEE11}, 8'h12, 8'h12, 8'h03};
    vecs[8] = '{8'h02, 16'd239, D0, S0, 16'h0000, 8'h00, 1'b1, 16'd0, 176'd0, 8'h00, 8'h00, 8'h00};
    vecs[9] = '{8'h00, 16'hFFFF, D0, S0, 16'h0000, 8'h00, 1'b1, 16'd0, 176'd0, 8'h00, 8'h00, 8'h00};

    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.length = '0;
    in_if.data   = '0;
    in_if.phv    = '0;
    out_if.ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_in_ready", in_if.ready, 1'b0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    check("rst_out_len", out_if.length, 16'd0);
    check("rst_out_data", out_if.data[HW-1 -: 512], 512'd0);
    check("rst_out_phv", out_if.phv, '0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_if.ready, 1'b1);

    exp_drops = 0;
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].len, make_phv(vecs[v].tags, vecs[v].dmac, vecs[v].smac, vecs[v].tci, vecs[v].b6));
      if (!vecs[v].drop) begin
        check($sformatf("v%0d_lat1_valid", v), out_if.valid, 1'b0);
        tick();
        exp_phv = make_phv(vecs[v].tags, vecs[v].dmac, vecs[v].smac, vecs[v].tci, vecs[v].b6);
        exp_phv[32 +: 8] = vecs[v].exp_b4;
        exp_phv[48 +: 8] = vecs[v].exp_b6;
        exp_phv[88 +: 8] = vecs[v].exp_w0;
        check($sformatf("v%0d_valid", v), out_if.valid, 1'b1);
        check($sformatf("v%0d_len", v), out_if.length, vecs[v].exp_len);
        check($sformatf("v%0d_hdr", v), out_if.data[HW-1 -: 176], vecs[v].exp_top);
        check($sformatf("v%0d_b4", v), out_if.phv[32 +: 8], vecs[v].exp_b4);
        check($sformatf("v%0d_b6", v), out_if.phv[48 +: 8], vecs[v].exp_b6);
        check($sformatf("v%0d_phv", v), out_if.phv, exp_phv);
        check($sformatf("v%0d_drop_cnt", v), drop_cnt, 32'(exp_drops));
        tick();
        check($sformatf("v%0d_single", v), out_if.valid, 1'b0);
      end else begin
        exp_drops++;
        seen = 0;
        repeat (4) begin
          if (out_if.valid) seen++;
          tick();
        end
        check($sformatf("v%0d_dropped", v), seen, 0);
        check($sformatf("v%0d_drop_cnt", v), drop_cnt, 32'(exp_drops));
      end
    end

    run_stream(1'b0);
    run_stream(1'b1);

    // Two beats in flight under backpressure, then reset.
    out_if.ready = 1'b0;
    send(16'd10, make_phv(8'h04, D0, S0, 16'h0000, 8'h00));
    send(16'd20, make_phv(8'h04, D0, S0, 16'h0000, 8'h00));
    tick();
    check("inflight_out_valid", out_if.valid, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_if.valid, 1'b0);
    check("midrst_drop_cnt", drop_cnt, 32'd0);
    check("midrst_in_ready", in_if.ready, 1'b0);
    rst = 1'b0;
    out_if.ready = 1'b1;
    bad = 0;
    repeat (6) begin
      if (out_if.valid) bad++;
      tick();
    end
    check("midrst_no_stale_out", bad, 0);
    send(16'd30, make_phv(8'h10, D0, S0, 16'h0000, 8'h00));
    tick();
    check("after_rst_valid", out_if.valid, 1'b1);
    check("after_rst_len", out_if.length, 16'd44);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
